// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider with run/stop sequencing and glitch-free factor changes.
// A new division factor only takes effect at a period boundary, or at once while stopped.
module clk_div_ctrl #(
   parameter int unsigned CW       = 8,
   parameter int unsigned DIV_INIT = 4
) (
   input  logic          clk_in,
   input  logic          rst_x,
   input  logic          i_run_en,
   input  logic          i_cfg_valid,
   input  logic [CW-1:0] i_cfg_div,
   output logic          o_cfg_ready,
   output logic          o_cfg_done,
   output logic          o_cfg_err,
   output logic          o_clk_out,
   output logic          o_tick,
   output logic          o_running,
   output logic [CW-1:0] o_div_cur
);

   typedef enum logic [0:0] {StStop, StRun} state_e;

   localparam logic [CW-1:0] DivInit = CW'(DIV_INIT);
   localparam logic [CW-1:0] DivMin  = CW'(2);

   state_e        r_state;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_div;
   logic [CW-1:0] r_hold;
   logic          r_pend;
   logic          r_clk;
   logic          r_tick;
   logic          r_done;
   logic          r_err;

   logic [CW-1:0] w_last;
   logic [CW-1:0] w_pre_last;
   logic [CW-1:0] w_half_m1;
   logic          w_at_last;
   logic          w_accept;
   logic          w_legal;

   // Period landmarks derived from the factor in effect, plus handshake decode.
   always_comb begin
      w_last     = r_div - CW'(1);
      w_pre_last = r_div - CW'(2);
      w_half_m1  = (r_div >> 1) - CW'(1);
      w_at_last  = (r_cnt == w_last);
      w_accept   = i_cfg_valid && !r_pend;
      w_legal    = (i_cfg_div >= DivMin);
   end

   // Run/stop FSM, period counter, registered waveform outputs and factor update.
   always_ff @(posedge clk_in or negedge rst_x) begin
      if (!rst_x) begin
         r_state <= StStop;
         r_cnt   <= '0;
         r_div   <= DivInit;
         r_hold  <= DivInit;
         r_pend  <= 1'b0;
         r_clk   <= 1'b1;
         r_tick  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            StStop: begin
               r_cnt  <= '0;
               r_clk  <= 1'b1;
               r_tick <= 1'b0;
               // While stopped there is no period to protect, so apply straight away;
               // if a start coincides, the new factor governs the first period.
               if (r_pend) begin
                  r_div  <= r_hold;
                  r_pend <= 1'b0;
                  r_done <= 1'b1;
               end
               if (i_run_en) begin
                  r_state <= StRun;
               end
            end
            StRun: begin
               if (w_at_last) begin
                  r_cnt  <= '0;
                  r_clk  <= 1'b1;
                  r_tick <= 1'b0;
                  if (r_pend) begin
                     r_div  <= r_hold;
                     r_pend <= 1'b0;
                     r_done <= 1'b1;
                  end
                  if (!i_run_en) begin
                     r_state <= StStop;
                  end
               end else begin
                  r_cnt  <= r_cnt + CW'(1);
                  // Registered tick must be high while the counter sits at N-1.
                  r_tick <= (r_cnt == w_pre_last);
                  if (r_cnt == w_half_m1) begin
                     r_clk <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= StStop;
            end
         endcase
         // Accept never coincides with an apply: it requires no pending factor.
         if (w_accept) begin
            if (w_legal) begin
               r_hold <= i_cfg_div;
               r_pend <= 1'b1;
            end else begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign o_cfg_ready = !r_pend;
   assign o_cfg_done  = r_done;
   assign o_cfg_err   = r_err;
   assign o_clk_out   = r_clk;
   assign o_tick      = r_tick;
   assign o_running   = (r_state == StRun);
   assign o_div_cur   = r_div;

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Runtime-programmable clock-divider controller for the GMSK BS clock generator.
- Generates a divided clock `clk_out` (registered, near-50% duty) and a one-cycle `tick` clock-enable.
- Owns run/stop sequencing and glitch-free changes of the division factor. A new factor is applied only at a period boundary, so no runt or stretched pulse is ever produced.
- Sits between the configuration/control register interface and downstream symbol-rate logic.

Parameters:
- CW, 8, counter and division-factor width. Legal factors are 2..2^CW-1.
- DIV_INIT, 4, factor loaded at reset. Must be in the legal range.

Ports:
- `clk_in`  in  1  source clock; all logic is on its rising edge.
- `rst_x`  in  1  asynchronous, active-low reset.
- `run_en`  in  1  level request: 1 = divider runs, 0 = stop at the next period boundary.
- `cfg_valid`  in  1  new division factor offered.
- `cfg_div`  in  CW  offered factor.
- `cfg_ready`  out  1  controller can accept a factor (no update pending).
- `cfg_done`  out  1  one-cycle pulse: a pending factor has been applied.
- `cfg_err`  out  1  one-cycle pulse: an accepted factor was illegal (<2) and was discarded.
- `clk_out`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle enable in the last `clk_in` cycle of each `clk_out` period.
- `running`  out  1  1 while in RUN.
- `div_cur`  out  CW  factor currently in effect.

Behaviour:
- Reset (`rst_x`=0, asynchronous):
  - state=STOP, cnt=0, `div_cur`=DIV_INIT, pending=0.
  - `clk_out`=1, `tick`=0, `running`=0, `cfg_ready`=1, `cfg_done`=0, `cfg_err`=0.
  - Reset mid-operation aborts any period or pending update immediately.
- Let N=`div_cur`, H=N/2 (integer division).
- STOP:
  - cnt held at 0, `clk_out` held 1, `tick`=0.
  - If `run_en`=1 → RUN next cycle, starting with cnt=0.
- RUN, counting:
  - cnt increments 0..N-1, then wraps to 0.
  - `clk_out` registered: it goes 0 in the cycle after cnt==H-1 and returns to 1 in the cycle after cnt==N-1.
  - High phase = H cycles, low phase = N-H cycles. Odd N gives the longer low phase.
  - `tick`=1 exactly while cnt==N-1.
- Boundary (RUN and cnt==N-1):
  - If pending=1: `div_cur` ← held factor, pending ← 0, `cfg_done` pulses in the next cycle. The new N governs the period starting at cnt=0.
  - If `run_en`=0: → STOP. `clk_out` rises as normal, then holds at 1.
  - Both events may occur at the same boundary: the factor is applied and the block stops.
- `run_en` deasserted mid-period: the current period completes fully; no truncation.
- `run_en` reasserted before the boundary: no effect; the divider keeps running.
- Config handshake:
  - Transfer occurs when `cfg_valid`&`cfg_ready`.
  - `cfg_ready` = !pending. It drops the cycle after an accepted legal factor.
  - Legal factor (≥2): held internally, pending=1.
    - In STOP it is applied in the next cycle: `div_cur` updated, pending cleared, `cfg_done` pulses, `cfg_ready` back to 1 one cycle later.
    - In RUN it waits for the boundary.
  - Illegal factor (0 or 1): accepted, discarded, `cfg_err` pulses the next cycle. pending and `div_cur` are unchanged.
  - `cfg_valid` while `cfg_ready`=0: ignored. The requester must hold `cfg_valid` until `cfg_ready`.
- Simultaneous STOP→RUN start and STOP-state apply in the same cycle: the new factor governs the first period.
- Counter never exceeds N-1; no wrap beyond 2^CW.
- Outputs are glitch-free: `clk_out` and `tick` come directly from flops.

Test Plan:
- Reset, `run_en`=1, DIV_INIT=4 → `clk_out` pattern 1,1,0,0 repeating; `tick` high on every 4th cycle; `running`=1 from the first cycle after `run_en`.
- Odd factor: cfg 5 in STOP, then run → `cfg_done` pulse, `div_cur`=5; `clk_out` high 2 cycles, low 3 cycles; `tick` period 5.
- Mid-period update: running N=4, cfg 6 at cnt=1 → `cfg_ready`=0 until boundary; current period stays 4 cycles, next period 6 cycles; `cfg_done` pulse right after the boundary.
- Illegal factor: cfg 1 → `cfg_err` pulse, `div_cur` unchanged, `cfg_ready` stays 1, waveform undisturbed.
- Stop sequencing: drop `run_en` at cnt=1 of N=8 → period completes 8 cycles, then STOP with `clk_out`=1, `tick`=0, `running`=0; reassert → restarts at cnt=0.
- Async reset asserted mid-low phase with an update pending → `clk_out`=1 and `div_cur`=DIV_INIT immediately; pending cleared, no `cfg_done`.
